// File: rtl/glitch_sched.sv
// Sweep scheduler for the glitch pulse stage: walks a (delay, width) grid, one fire per trigger edge.
// Optional ARM timeout with point skipping is compiled in when GLITCH_TRIG_TIMEOUT_EN is defined.
module glitch_sched #(
  parameter int DELAY_W = 16,
  parameter int HOLDOFF = 512,
  parameter int TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               trig_in,
  input  logic [DELAY_W-1:0] delay_min,
  input  logic [DELAY_W-1:0] delay_max,
  input  logic [DELAY_W-1:0] delay_step,
  input  logic [7:0]         width_min,
  input  logic [7:0]         width_max,
  input  logic [7:0]         width_step,
  output logic               pulse_en,
  output logic [7:0]         pulse_width,
  output logic [DELAY_W-1:0] cur_delay,
  output logic               busy,
  output logic               done,
  output logic [15:0]        attempt_cnt,
  output logic               timeout
);

  localparam int HOLD_W = $clog2(HOLDOFF + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    DELAY,
    FIRE,
    HOLD,
    DONE
  } state_t;

  state_t state_reg;

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;
  logic trig_edge;

  // delay_min is captured straight into cur_delay; the delay loop never rewinds.
  logic [DELAY_W-1:0] dmax_reg;
  logic [DELAY_W-1:0] dstep_reg;
  logic [7:0]         wmin_reg;
  logic [7:0]         wmax_reg;
  logic [7:0]         wstep_reg;

  logic [DELAY_W-1:0] dly_cnt_reg;
  logic [HOLD_W-1:0]  hold_cnt_reg;
  logic [7:0]         next_width_reg;
  logic [DELAY_W-1:0] next_delay_reg;
  logic               last_reg;

  logic [8:0]         width_sum;
  logic [DELAY_W:0]   delay_sum;
  logic               width_wrap;
  logic               sweep_end;
  logic [7:0]         width_next;
  logic [DELAY_W-1:0] delay_next;
  logic               arm_expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= trig_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign trig_edge = sync2_reg & ~prev_reg;

  // Next grid point: width is the inner loop; sums are one bit wider so nothing wraps.
  always_comb begin
    width_sum  = {1'b0, pulse_width} + {1'b0, wstep_reg};
    delay_sum  = {1'b0, cur_delay} + {1'b0, dstep_reg};
    width_wrap = width_sum > {1'b0, wmax_reg};
    sweep_end  = width_wrap && (delay_sum > {1'b0, dmax_reg});
    width_next = width_wrap ? wmin_reg : width_sum[7:0];
    delay_next = width_wrap ? delay_sum[DELAY_W-1:0] : cur_delay;
  end

`ifdef GLITCH_TRIG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] arm_cnt_reg;
  logic            start_accept;

  assign start_accept = ((state_reg == IDLE) || (state_reg == DONE)) && start && !abort;
  assign arm_expired  = (state_reg == ARM) && !trig_edge && (arm_cnt_reg == TO_W'(TIMEOUT - 1));

  // Counter restarts on every ARM entry, including the re-entry after a skipped point.
  always_ff @(posedge clk) begin
    if (rst || abort || (state_reg != ARM) || trig_edge || arm_expired) begin
      arm_cnt_reg <= '0;
    end else begin
      arm_cnt_reg <= arm_cnt_reg + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout <= 1'b0;
    end else if (start_accept) begin
      timeout <= 1'b0;
    end else if (arm_expired && !abort) begin
      timeout <= 1'b1;
    end
  end
`else
  assign arm_expired = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pulse_en       <= 1'b0;
      pulse_width    <= 8'd0;
      cur_delay      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      attempt_cnt    <= 16'd0;
      dmax_reg       <= '0;
      dstep_reg      <= DELAY_W'(1);
      wmin_reg       <= 8'd0;
      wmax_reg       <= 8'd0;
      wstep_reg      <= 8'd1;
      dly_cnt_reg    <= '0;
      hold_cnt_reg   <= '0;
      next_width_reg <= 8'd0;
      next_delay_reg <= '0;
      last_reg       <= 1'b0;
    end else if (abort) begin
      state_reg <= IDLE;
      pulse_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pulse_en <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            dmax_reg    <= delay_max;
            dstep_reg   <= (delay_step == '0) ? DELAY_W'(1) : delay_step;
            wmin_reg    <= width_min;
            wmax_reg    <= width_max;
            wstep_reg   <= (width_step == 8'd0) ? 8'd1 : width_step;
            cur_delay   <= delay_min;
            pulse_width <= width_min;
            attempt_cnt <= 16'd0;
            done        <= 1'b0;
            busy        <= 1'b1;
            state_reg   <= ARM;
          end
        end
        ARM: begin
          // Zero delay bypasses DELAY so the strobe lands one cycle after the edge.
          if (trig_edge) begin
            if (cur_delay == '0) begin
              pulse_en  <= 1'b1;
              state_reg <= FIRE;
            end else begin
              dly_cnt_reg <= cur_delay - DELAY_W'(1);
              state_reg   <= DELAY;
            end
          end else if (arm_expired) begin
            if (sweep_end) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              pulse_width <= width_next;
              cur_delay   <= delay_next;
            end
          end
        end
        DELAY: begin
          if (dly_cnt_reg == '0) begin
            pulse_en  <= 1'b1;
            state_reg <= FIRE;
          end else begin
            dly_cnt_reg <= dly_cnt_reg - DELAY_W'(1);
          end
        end
        FIRE: begin
          attempt_cnt    <= attempt_cnt + 16'd1;
          next_width_reg <= width_next;
          next_delay_reg <= delay_next;
          last_reg       <= sweep_end;
          hold_cnt_reg   <= HOLD_W'(HOLDOFF - 1);
          state_reg      <= HOLD;
        end
        HOLD: begin
          // The fired point stays on the outputs until the pulse stage has surely finished.
          if (hold_cnt_reg == '0) begin
            if (last_reg) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              pulse_width <= next_width_reg;
              cur_delay   <= next_delay_reg;
              state_reg   <= ARM;
            end
          end else begin
            hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
